// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: host-request to async SRAM bridge with SETUP/STROBE/HOLD timing and a
// tri-state data bus. Strobes are registered from the next state so they never glitch.
module data_ram_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw_n,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_ebit,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ebit,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_we_n,
    output logic              mem_oe_n
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;
    localparam logic [3:0] LAST   = 4'(WAIT_STATES);

    logic [1:0]        state, nstate;
    logic [3:0]        cnt;
    logic              rw_n;
    logic [DATA_W-1:0] wdata;
    logic              last;

    assign last      = (cnt == LAST);
    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == HOLD);
    assign mem_data  = (state != IDLE && !rw_n) ? wdata : {DATA_W{1'bz}};

    always_comb begin
        nstate = (state == IDLE)   ? (req_valid ? SETUP : IDLE) :
                 (state == SETUP)  ? STROBE :
                 (state == STROBE) ? (last ? HOLD : STROBE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rw_n      <= 1'b1;
            mem_addr  <= '0;
            mem_ebit  <= 1'b0;
            wdata     <= '0;
            rsp_rdata <= '0;
            mem_we_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
        end else begin
            state <= nstate;
            cnt   <= (state == STROBE) ? cnt + 4'd1 : 4'd0;
            if (req_ready && req_valid) begin
                rw_n     <= req_rw_n;
                mem_addr <= req_addr;
                mem_ebit <= req_ebit;
                wdata    <= req_wdata;
            end
            if (state == STROBE && last && rw_n)
                rsp_rdata <= mem_data;
            mem_we_n <= !(nstate == STROBE && !rw_n);
            mem_oe_n <= !(nstate == STROBE && rw_n);
        end
    end
endmodule
